// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C controller APB command sequencer.
// Op encodings, FSM states and APB bus widths.
package i2c_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_RSP
    } state_e;

    function automatic logic poll_hit(
        input logic [APB_DW-1:0] data,
        input logic [APB_DW-1:0] expv,
        input logic [APB_DW-1:0] mask
    );
        return ((data ^ expv) & mask) == '0;
    endfunction

endpackage

// File: rtl/i2c_apb_seq.sv
// APB master sequencer: runs one write/read/poll command at a time
// against the I2C controller's APB slave and returns one response.
module i2c_apb_seq
    import i2c_pkg::*;
#(
    parameter int POLL_GAP    = 4,
    parameter int MAX_POLLS   = 1024,
    parameter int ACC_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [APB_AW-1:0] req_addr,
    input  logic [APB_DW-1:0] req_wdata,
    input  logic [APB_DW-1:0] req_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              apb_sel,
    output logic              apb_en,
    output logic              apb_write,
    input  logic              apb_ready,
    output logic [APB_AW-1:0] apb_addr,
    output logic [APB_DW-1:0] apb_wdata,
    input  logic [APB_DW-1:0] apb_rdata
);

    localparam int PW = $clog2(MAX_POLLS) + 1;
    localparam int AW = $clog2(ACC_TIMEOUT) + 1;
    localparam int GW = $clog2(POLL_GAP) + 1;

    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);
    localparam logic [AW-1:0] ACC_LAST  = AW'(ACC_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

    state_e            state;
    op_e               op_q;
    logic [APB_DW-1:0] mask_q;
    logic [PW-1:0]     poll_cnt;
    logic [AW-1:0]     acc_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              hit;

    assign hit = poll_hit(apb_rdata, apb_wdata, mask_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_WR;
            mask_q    <= '0;
            poll_cnt  <= '0;
            acc_cnt   <= '0;
            gap_cnt   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            apb_sel   <= 1'b0;
            apb_en    <= 1'b0;
            apb_write <= 1'b0;
            apb_addr  <= '0;
            apb_wdata <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= op_e'(req_op);
                        mask_q    <= req_mask;
                        apb_addr  <= req_addr;
                        apb_wdata <= req_wdata;
                        poll_cnt  <= '0;
                        if (op_e'(req_op) == OP_RSVD) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            state     <= S_RSP;
                        end else begin
                            apb_sel   <= 1'b1;
                            apb_write <= (op_e'(req_op) == OP_WR);
                            state     <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    apb_en  <= 1'b1;
                    acc_cnt <= '0;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    acc_cnt <= acc_cnt + 1'b1;
                    if (apb_ready) begin
                        apb_sel <= 1'b0;
                        apb_en  <= 1'b0;
                        if (op_q == OP_POLL && !hit && poll_cnt != POLL_LAST) begin
                            poll_cnt <= poll_cnt + 1'b1;
                            gap_cnt  <= '0;
                            state    <= S_GAP;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= (op_q == OP_WR) ? '0 : apb_rdata;
                            rsp_err   <= (op_q == OP_POLL) && !hit;
                            state     <= S_RSP;
                        end
                    end else if (acc_cnt == ACC_LAST) begin
                        // slave never answered: abort the access
                        apb_sel   <= 1'b0;
                        apb_en    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= S_RSP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        apb_sel <= 1'b1;
                        state   <= S_SETUP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_apb_seq.sv
// Directed self-checking bench for i2c_apb_seq.
// Small parameters keep poll exhaustion and timeout short.
module tb_i2c_apb_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_mask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        apb_sel;
    logic        apb_en;
    logic        apb_write;
    logic        apb_ready = 1'b0;
    logic [31:0] apb_addr;
    logic [31:0] apb_wdata;
    logic [31:0] apb_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    i2c_apb_seq #(
        .POLL_GAP(4),
        .MAX_POLLS(4),
        .ACC_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_mask(req_mask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .apb_sel(apb_sel),
        .apb_en(apb_en),
        .apb_write(apb_write),
        .apb_ready(apb_ready),
        .apb_addr(apb_addr),
        .apb_wdata(apb_wdata),
        .apb_rdata(apb_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] mk);
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_mask  = mk;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp(input string tag, input logic [31:0] rd,
                              input logic err);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_rdata"}, rsp_rdata, rd);
        chk({tag, "_err"}, rsp_err, err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, rsp_valid, 0);
    endtask

    task automatic watch(input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, output int reads,
                         output int idle_min, output int idle_max);
        int idle = 0;
        int n = 0;
        reads = 0;
        idle_min = 999;
        idle_max = 0;
        apb_ready = 1'b1;
        while (!rsp_valid && n < 200) begin
            if (apb_sel) begin
                if (idle > 0) begin
                    if (idle < idle_min) idle_min = idle;
                    if (idle > idle_max) idle_max = idle;
                    idle = 0;
                end
                if (apb_en) begin
                    apb_rdata = (reads == 0) ? v0 : (reads == 1) ? v1 : v2;
                    reads++;
                end
            end else begin
                idle++;
            end
            step();
            n++;
        end
        apb_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads, imin, imax, acc, sel_seen;

        step();
        step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_sel_en", {apb_sel, apb_en, apb_write}, 0);
        chk("rst_addr", apb_addr, 0);
        chk("rst_wdata", apb_wdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;

        // write, zero wait states
        apb_ready = 1'b1;
        issue(2'b00, 32'h04, 32'h5A, 32'h0);
        chk("wr_setup", {apb_sel, apb_en, apb_write}, 3'b101);
        chk("wr_addr", apb_addr, 32'h04);
        chk("wr_wdata", apb_wdata, 32'h5A);
        chk("wr_busy", req_ready, 0);
        step();
        chk("wr_access", {apb_sel, apb_en, apb_write}, 3'b111);
        step();
        apb_ready = 1'b0;
        chk("wr_lat3", rsp_valid, 1);
        chk("wr_bus_idle", {apb_sel, apb_en}, 0);
        finish_rsp("wr", 32'h0, 1'b0);

        // read with 5 wait states
        issue(2'b01, 32'h10, 32'h0, 32'h0);
        chk("rd_setup", {apb_sel, apb_en, apb_write}, 3'b100);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rd_wait", {apb_sel, apb_en, apb_write}, 3'b110);
            chk("rd_wait_addr", apb_addr, 32'h10);
        end
        step();
        chk("rd_last", {apb_sel, apb_en}, 2'b11);
        apb_ready = 1'b1;
        apb_rdata = 32'hA5;
        step();
        apb_ready = 1'b0;
        apb_rdata = 32'h0;
        finish_rsp("rd", 32'hA5, 1'b0);

        // poll succeeds on third read
        issue(2'b10, 32'h08, 32'h80, 32'h80);
        watch(32'h00, 32'h00, 32'h81, reads, imin, imax);
        chk("poll_reads", reads, 3);
        chk("poll_gap_min", imin, 4);
        chk("poll_gap_max", imax, 4);
        finish_rsp("poll", 32'h81, 1'b0);

        // poll exhausts after MAX_POLLS reads
        issue(2'b10, 32'h08, 32'h01, 32'h01);
        watch(32'h00, 32'h00, 32'h00, reads, imin, imax);
        chk("exh_reads", reads, 4);
        chk("exh_gap", imin, 4);
        finish_rsp("exh", 32'h0, 1'b1);

        // mask 0 matches on first read
        issue(2'b10, 32'h0C, 32'hFF, 32'h0);
        watch(32'h33, 32'h44, 32'h55, reads, imin, imax);
        chk("mask0_reads", reads, 1);
        finish_rsp("mask0", 32'h33, 1'b0);

        // access timeout, then response backpressure
        issue(2'b01, 32'h20, 32'h0, 32'h0);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (apb_sel && apb_en) acc++;
            if (rsp_valid) break;
        end
        chk("to_cycles", acc, 8);
        chk("to_bus_idle", {apb_sel, apb_en}, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_hold", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
            chk("bp_req_ready", req_ready, 0);
            step();
        end
        finish_rsp("to", 32'h0, 1'b1);

        // reserved op: no bus activity
        issue(2'b11, 32'h30, 32'h0, 32'h0);
        sel_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (apb_sel) sel_seen = 1;
            if (rsp_valid) break;
            step();
        end
        chk("rsvd_no_sel", sel_seen, 0);
        finish_rsp("rsvd", 32'h0, 1'b1);

        // reset in the middle of an access
        issue(2'b00, 32'h14, 32'h77, 32'h0);
        step();
        chk("mid_access", {apb_sel, apb_en}, 2'b11);
        rst = 1'b1;
        step();
        chk("mid_rst_bus", {apb_sel, apb_en, rsp_valid}, 0);
        chk("mid_rst_ready", req_ready, 0);
        rst = 1'b0;
        apb_ready = 1'b1;
        issue(2'b00, 32'h18, 32'h99, 32'h0);
        chk("post_rst_setup", {apb_sel, apb_en, apb_write}, 3'b101);
        chk("post_rst_addr", apb_addr, 32'h18);
        step();
        step();
        apb_ready = 1'b0;
        finish_rsp("post_rst", 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
